// File: rtl/mips_cpu_load_writeback.sv
// mips_cpu_load_writeback: retires ALU results and byte/half/word/unaligned loads into the register file
module mips_cpu_load_writeback #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_type,
   input  logic [4:0]  req_dest,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_alu_data,
   input  logic [31:0] req_old_rt,
   output logic        mem_read,
   output logic [31:0] mem_address,
   output logic [3:0]  mem_byteenable,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   output logic        rf_write,
   output logic [4:0]  rf_wrAddr,
   output logic [31:0] rf_wrData,
   output logic        busy,
   output logic        addr_err,
   output logic        mem_timeout
);
   localparam int CW = WAIT_LIMIT > 1 ? $clog2(WAIT_LIMIT + 1) : 1;
   typedef enum logic [1:0] {S_IDLE, S_MEM, S_WRITE} state_t;
   state_t        r_state, w_next;
   logic [2:0]    r_type;
   logic [4:0]    r_dest;
   logic [1:0]    r_a;
   logic [31:0]   r_rt, r_mem_address, r_wr_data;
   logic [4:0]    r_wr_addr;
   logic [CW-1:0] r_cnt;
   logic          r_addr_err, r_timeout;
   logic          w_accept, w_misalign, w_done, w_expire;
   logic [4:0]    w_sh;
   logic [31:0]   w_shr, w_load;
   assign w_accept   = req_valid && r_state == S_IDLE;
   assign w_misalign = ((req_type == 3'd3 || req_type == 3'd4) && req_addr[0]) ||
                       (req_type == 3'd5 && req_addr[1:0] != 2'd0);
   assign w_done     = r_state == S_MEM && !mem_waitrequest;
   assign w_expire   = r_state == S_MEM && mem_waitrequest && WAIT_LIMIT != 0 &&
                       r_cnt == CW'(WAIT_LIMIT - 1);
   // little-endian lane select: shift the addressed byte down to bit 0
   always_comb begin
      w_sh   = {r_a, 3'b000};
      w_shr  = mem_readdata >> w_sh;
      w_load = r_type == 3'd1 ? {{24{w_shr[7]}}, w_shr[7:0]} :
               r_type == 3'd2 ? {24'd0, w_shr[7:0]} :
               r_type == 3'd3 ? {{16{w_shr[15]}}, w_shr[15:0]} :
               r_type == 3'd4 ? {16'd0, w_shr[15:0]} :
               r_type == 3'd5 ? mem_readdata :
               r_type == 3'd6 ? (mem_readdata << (5'd24 - w_sh)) | (r_rt & (32'h00FF_FFFF >> w_sh)) :
                                w_shr | (r_rt & ~(32'hFFFF_FFFF >> w_sh));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_type        <= 3'd0;
         r_dest        <= 5'd0;
         r_a           <= 2'd0;
         r_rt          <= 32'd0;
         r_mem_address <= 32'd0;
         r_wr_addr     <= 5'd0;
         r_wr_data     <= 32'd0;
         r_cnt         <= '0;
         r_addr_err    <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_addr_err <= w_accept && req_type != 3'd0 && w_misalign;
         r_timeout  <= r_timeout | w_expire;
         r_cnt      <= w_accept ? '0 : (r_state == S_MEM && mem_waitrequest) ? r_cnt + 1'b1 : r_cnt;
         if (w_accept) begin
            r_type <= req_type;
            r_dest <= req_dest;
            r_a    <= req_addr[1:0];
            r_rt   <= req_old_rt;
         end
         if (w_accept && req_type != 3'd0 && !w_misalign)
            r_mem_address <= {req_addr[31:2], 2'b00};
         if (w_accept && req_type == 3'd0 && req_dest != 5'd0) begin
            r_wr_addr <= req_dest;
            r_wr_data <= req_alu_data;
         end else if (w_done && r_dest != 5'd0) begin
            r_wr_addr <= r_dest;
            r_wr_data <= w_load;
         end
      end
   end
   always_comb begin
      w_next = r_state == S_WRITE ? S_IDLE :
               r_state == S_MEM   ? (w_done ? S_WRITE : w_expire ? S_IDLE : S_MEM) :
               !w_accept          ? S_IDLE :
               req_type == 3'd0   ? S_WRITE :
               w_misalign         ? S_IDLE : S_MEM;
   end
   always_comb begin
      req_ready      = r_state == S_IDLE;
      busy           = r_state != S_IDLE;
      mem_read       = r_state == S_MEM;
      mem_byteenable = {4{r_state == S_MEM}};
      mem_address    = r_mem_address;
      rf_write       = r_state == S_WRITE && r_dest != 5'd0;
      rf_wrAddr      = r_wr_addr;
      rf_wrData      = r_wr_data;
      addr_err       = r_addr_err;
      mem_timeout    = r_timeout;
   end
endmodule
